// File: rtl/atm_txn_ctrl.sv
// ATM transaction controller: card/PIN gate, staged deposit and withdraw, one-cycle dispense.
// Optional inactivity timeout is built only when ATM_TIMEOUT_EN is defined.
module atm_txn_ctrl #(
  parameter int unsigned STEP_AMT    = 100,
  parameter int unsigned MAX_BAL     = 50000,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        card_in,
  input  logic        pin_ok,
  input  logic        up_button,
  input  logic        down_button,
  input  logic        confirm,
  input  logic        cancel,
  output logic [15:0] balance,
  output logic [15:0] pending,
  output logic        dispense,
  output logic        err,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAuth = 3'd1,
    StMenu = 3'd2,
    StDep  = 3'd3,
    StWdr  = 3'd4,
    StDisp = 3'd5
  } state_e;

  localparam logic [15:0] Step  = 16'(STEP_AMT);
  localparam logic [16:0] StepW = 17'(STEP_AMT);
  localparam logic [16:0] MaxW  = 17'(MAX_BAL);

  state_e      state_q;
  logic [15:0] balance_q, pending_q;
  logic        err_q;
  logic        card_q, up_q, down_q, confirm_q, cancel_q;
  logic        card_rise, up_p, down_p, confirm_p, cancel_p;
  logic [16:0] dep_sum, wdr_sum;
  logic        dep_ok, wdr_ok;
  logic        tmo_fire;

  assign card_rise = card_in & ~card_q;
  assign up_p      = up_button & ~up_q;
  assign down_p    = down_button & ~down_q;
  assign confirm_p = confirm & ~confirm_q;
  assign cancel_p  = cancel & ~cancel_q;

  // Limit checks carried one bit wider so the sums can never wrap.
  assign dep_sum = {1'b0, balance_q} + {1'b0, pending_q} + StepW;
  assign dep_ok  = (dep_sum <= MaxW);
  assign wdr_sum = {1'b0, pending_q} + StepW;
  assign wdr_ok  = (wdr_sum <= {1'b0, balance_q});

`ifdef ATM_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

  logic [TmoW-1:0] tmo_q, tmo_cur;
  state_e          last_q;
  logic            tmo_idle;

  // A state change restarts the count, so the entry cycle counts as idle cycle one.
  assign tmo_idle = (state_q inside {StAuth, StMenu, StDep, StWdr}) &&
                    !(up_p || down_p || confirm_p || cancel_p);
  assign tmo_cur  = (state_q != last_q) ? '0 : tmo_q;
  assign tmo_fire = tmo_idle && ((32'(tmo_cur) + 32'd1) >= TIMEOUT_CYC);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q  <= '0;
      last_q <= StIdle;
    end else begin
      last_q <= state_q;
      tmo_q  <= tmo_idle ? tmo_cur + 1'b1 : '0;
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      balance_q <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      card_q    <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      confirm_q <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      card_q    <= card_in;
      up_q      <= up_button;
      down_q    <= down_button;
      confirm_q <= confirm;
      cancel_q  <= cancel;
      err_q     <= 1'b0;
      if (state_q != StIdle && !card_in) begin
        state_q   <= StIdle;
        pending_q <= '0;
      end else if (tmo_fire) begin
        state_q   <= StIdle;
        pending_q <= '0;
        err_q     <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: if (card_rise) state_q <= StAuth;
          StAuth: if (pin_ok) state_q <= StMenu;
          StMenu: begin
            if (up_p && !down_p) begin
              state_q   <= StDep;
              pending_q <= Step;
            end else if (down_p && !up_p) begin
              if (balance_q < Step) begin
                err_q <= 1'b1;
              end else begin
                state_q   <= StWdr;
                pending_q <= Step;
              end
            end
          end
          StDep: begin
            if (cancel_p) begin
              state_q   <= StMenu;
              pending_q <= '0;
            end else if (confirm_p) begin
              state_q   <= StMenu;
              balance_q <= balance_q + pending_q;
              pending_q <= '0;
            end else if (up_p) begin
              if (dep_ok) pending_q <= pending_q + Step;
              else        err_q     <= 1'b1;
            end
          end
          StWdr: begin
            if (cancel_p) begin
              state_q   <= StMenu;
              pending_q <= '0;
            end else if (confirm_p) begin
              if (pending_q == '0) begin
                state_q <= StMenu;
              end else begin
                state_q   <= StDisp;
                balance_q <= balance_q - pending_q;
              end
            end else if (down_p) begin
              if (wdr_ok) pending_q <= pending_q + Step;
              else        err_q     <= 1'b1;
            end
          end
          StDisp: begin
            state_q   <= StMenu;
            pending_q <= '0;
          end
          default: begin
            state_q   <= StIdle;
            pending_q <= '0;
          end
        endcase
      end
    end
  end

  assign balance  = balance_q;
  assign pending  = pending_q;
  assign err      = err_q;
  assign state    = state_q;
  assign dispense = (state_q == StDisp);

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Directed scoreboard bench for atm_txn_ctrl; instance b uses MAX_BAL=200 and TIMEOUT_CYC=8.
module tb_atm_txn_ctrl;

  localparam logic [2:0] SIdle = 3'd0;
  localparam logic [2:0] SAuth = 3'd1;
  localparam logic [2:0] SMenu = 3'd2;
  localparam logic [2:0] SDep  = 3'd3;
  localparam logic [2:0] SWdr  = 3'd4;
  localparam logic [2:0] SDisp = 3'd5;

  logic clk, rst, card_in, pin_ok, up_button, down_button, confirm, cancel;
  logic [15:0] a_balance, a_pending, b_balance, b_pending;
  logic        a_dispense, a_err, b_dispense, b_err;
  logic [2:0]  a_state, b_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    bit          sel;
    logic [2:0]  st;
    logic [15:0] bal;
    logic [15:0] pend;
    logic        disp;
    logic        err;
  } exp_t;

  exp_t sb[$];

  atm_txn_ctrl #(.STEP_AMT(100), .MAX_BAL(50000), .TIMEOUT_CYC(1000)) dut_a (
    .clk(clk), .rst(rst), .card_in(card_in), .pin_ok(pin_ok), .up_button(up_button),
    .down_button(down_button), .confirm(confirm), .cancel(cancel), .balance(a_balance),
    .pending(a_pending), .dispense(a_dispense), .err(a_err), .state(a_state)
  );

  atm_txn_ctrl #(.STEP_AMT(100), .MAX_BAL(200), .TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst(rst), .card_in(card_in), .pin_ok(pin_ok), .up_button(up_button),
    .down_button(down_button), .confirm(confirm), .cancel(cancel), .balance(b_balance),
    .pending(b_pending), .dispense(b_dispense), .err(b_err), .state(b_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input string tag, input logic [2:0] st, input int bal,
                      input int pend, input logic disp, input logic e);
    exp_t x;
    x.tag = tag; x.sel = sel; x.st = st; x.bal = 16'(bal); x.pend = 16'(pend);
    x.disp = disp; x.err = e;
    sb.push_back(x);
  endtask

  task automatic ea(input string tag, input logic [2:0] st, input int bal, input int pend,
                    input logic disp, input logic e);
    push(1'b0, tag, st, bal, pend, disp, e);
  endtask

  task automatic eb(input string tag, input logic [2:0] st, input int bal, input int pend,
                    input logic disp, input logic e);
    push(1'b1, tag, st, bal, pend, disp, e);
  endtask

  task automatic check_out();
    exp_t x;
    logic [2:0]  st;
    logic [15:0] bal, pend;
    logic        disp, e;
    while (sb.size() != 0) begin
      x = sb.pop_front();
      st   = x.sel ? b_state    : a_state;
      bal  = x.sel ? b_balance  : a_balance;
      pend = x.sel ? b_pending  : a_pending;
      disp = x.sel ? b_dispense : a_dispense;
      e    = x.sel ? b_err      : a_err;
      cmp({x.tag, ".state"}, 16'(st), 16'(x.st));
      cmp({x.tag, ".balance"}, bal, x.bal);
      cmp({x.tag, ".pending"}, pend, x.pend);
      cmp({x.tag, ".dispense"}, 16'(disp), 16'(x.disp));
      cmp({x.tag, ".err"}, 16'(e), 16'(x.err));
    end
  endtask

  task automatic drive(input logic c, input logic p, input logic u, input logic d,
                       input logic cf, input logic cn);
    card_in = c; pin_ok = p; up_button = u; down_button = d; confirm = cf; cancel = cn;
  endtask

  task automatic tick();
    @(negedge clk);
    check_out();
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #3;
    ea("reset", SIdle, 0, 0, 0, 0); check_out();
    @(negedge clk); rst = 1'b1;

    // Build pending=300 in DEP, then reset asynchronously mid-cycle.
    drive(1, 0, 0, 0, 0, 0); ea("a_card", SAuth, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("a_pin", SMenu, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 1, 0, 0, 0); ea("a_up", SDep, 0, 100 * i, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); ea("a_up_rel", SDep, 0, 100 * i, 0, 0); tick();
    end
    #2; rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    #1; ea("async_rst", SIdle, 0, 0, 0, 0); check_out();
    @(negedge clk); rst = 1'b1;

    // Deposit path.
    drive(1, 0, 0, 0, 0, 0); ea("dep_card", SAuth, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("dep_pin", SMenu, 0, 0, 0, 0); tick();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 1, 0, 0, 0); ea("dep_up", SDep, 0, 100 * i, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); ea("dep_up_rel", SDep, 0, 100 * i, 0, 0); tick();
    end
    drive(1, 1, 0, 0, 1, 0); ea("dep_confirm", SMenu, 300, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("dep_idle", SMenu, 300, 0, 0, 0); tick();

    // Withdraw path with one-cycle dispense.
    for (int i = 1; i <= 2; i++) begin
      drive(1, 1, 0, 1, 0, 0); ea("wdr_down", SWdr, 300, 100 * i, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0); ea("wdr_down_rel", SWdr, 300, 100 * i, 0, 0); tick();
    end
    drive(1, 1, 0, 0, 1, 0); ea("wdr_disp", SDisp, 100, 200, 1, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("wdr_done", SMenu, 100, 0, 0, 0); tick();

    // Overdraw attempt, then cancel.
    drive(1, 1, 0, 1, 0, 0); ea("ovd_down1", SWdr, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("ovd_rel1", SWdr, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 1, 0, 0); ea("ovd_down2", SWdr, 100, 100, 0, 1); tick();
    drive(1, 1, 0, 0, 0, 0); ea("ovd_err_clr", SWdr, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 1); ea("ovd_cancel", SMenu, 100, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("ovd_idle", SMenu, 100, 0, 0, 0); tick();

    // Simultaneous keys: up+down ignored in MENU, cancel beats confirm.
    drive(1, 1, 1, 1, 0, 0); ea("updown", SMenu, 100, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("updown_rel", SMenu, 100, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 0); ea("cc_up", SDep, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("cc_rel", SDep, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 1, 1); ea("cc_both", SMenu, 100, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("cc_idle", SMenu, 100, 0, 0, 0); tick();

    // Held key counts once; card removal drops to IDLE.
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 0, 0, 0); ea("held_up", SDep, 100, 100, 0, 0); tick();
    end
    drive(0, 1, 0, 0, 0, 0); ea("card_out", SIdle, 100, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0); ea("card_out_idle", SIdle, 100, 0, 0, 0); tick();

    // Fresh start for both instances.
    rst = 1'b0;
    #1; ea("rst2", SIdle, 0, 0, 0, 0); eb("b_rst2", SIdle, 0, 0, 0, 0); check_out();
    @(negedge clk); rst = 1'b1;
    drive(1, 0, 0, 0, 0, 0); ea("r_card", SAuth, 0, 0, 0, 0); eb("b_card", SAuth, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0); ea("r_pin", SMenu, 0, 0, 0, 0); eb("b_pin", SMenu, 0, 0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 0); ea("entry_err", SMenu, 0, 0, 0, 1); tick();
    drive(1, 1, 0, 0, 0, 0); ea("entry_clr", SMenu, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 0); ea("r_up", SDep, 0, 100, 0, 0); eb("b_up", SDep, 0, 100, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 0); ea("r_rel", SDep, 0, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 1, 0); ea("r_conf", SMenu, 100, 0, 0, 0);
    eb("b_conf", SMenu, 100, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); ea("r_idle", SMenu, 100, 0, 0, 0); tick();

    // Deposit ceiling on instance b (MAX_BAL=200).
    drive(1, 1, 1, 0, 0, 0); ea("ceil_up1", SDep, 100, 100, 0, 0);
    eb("b_ceil_up1", SDep, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 1, 0, 0, 0); ea("ceil_up2", SDep, 100, 200, 0, 0);
    eb("b_ceil_up2", SDep, 100, 100, 0, 1); tick();
    drive(1, 1, 0, 0, 0, 0); ea("ceil_rel", SDep, 100, 200, 0, 0);
    eb("b_ceil_rel", SDep, 100, 100, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 1); ea("ceil_cancel", SMenu, 100, 0, 0, 0);
    eb("b_ceil_cancel", SMenu, 100, 0, 0, 0); tick();

    // Inactivity in MENU: b times out only when the feature is built.
    for (int i = 1; i <= 7; i++) begin
      drive(1, 1, 0, 0, 0, 0); ea("tmo_a", SMenu, 100, 0, 0, 0);
      eb("tmo_b_wait", SMenu, 100, 0, 0, 0); tick();
    end
`ifdef ATM_TIMEOUT_EN
    eb("tmo_b_fire", SIdle, 100, 0, 0, 1); ea("tmo_a8", SMenu, 100, 0, 0, 0); tick();
    eb("tmo_b_after", SIdle, 100, 0, 0, 0); ea("tmo_a9", SMenu, 100, 0, 0, 0); tick();
`else
    eb("no_tmo_b8", SMenu, 100, 0, 0, 0); ea("tmo_a8", SMenu, 100, 0, 0, 0); tick();
    eb("no_tmo_b9", SMenu, 100, 0, 0, 0); ea("tmo_a9", SMenu, 100, 0, 0, 0); tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_txn_ctrl.md
ATM_TXN_CTRL -- requirements
Module: atm_txn_ctrl

Interface
REQ-001 Parameter STEP_AMT, default 100, amount added to the pending value per accepted button press.
REQ-002 Parameter MAX_BAL, default 50000, maximum account balance; the balance never exceeds this value.
REQ-003 Parameter TIMEOUT_CYC, default 1000, inactivity limit in clk cycles (used only when ATM_TIMEOUT_EN is defined).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 card_in  input  1  level, high while a card is inserted.
REQ-007 pin_ok  input  1  level, PIN verified by the upstream checker.
REQ-008 up_button  input  1  deposit key, level.
REQ-009 down_button  input  1  withdraw key, level.
REQ-010 confirm  input  1  confirm key, level.
REQ-011 cancel  input  1  cancel key, level.
REQ-012 balance  output  16  committed account balance, registered.
REQ-013 pending  output  16  amount staged in the current deposit or withdraw, registered.
REQ-014 dispense  output  1  cash-dispense strobe.
REQ-015 err  output  1  one-cycle error strobe.
REQ-016 state  output  3  current FSM state encoding.

Function
REQ-017 Key handling: up_button, down_button, confirm and cancel each SHALL be rising-edge detected against a registered copy; a held key counts as one press; only presses act below.
REQ-018 States and encoding: IDLE=0, AUTH=1, MENU=2, DEP=3, WDR=4, DISP=5.
REQ-019 IDLE: on a card_in rising edge, go to AUTH.
REQ-020 AUTH: if pin_ok=1, go to MENU.
REQ-021 MENU:
- up press with no down press -> DEP, pending=STEP_AMT.
- down press with no up press -> WDR, pending=STEP_AMT.
- up and down pressed in the same cycle -> both ignored, stay in MENU.
REQ-022 DEP:
- up press: pending+=STEP_AMT if balance+pending+STEP_AMT<=MAX_BAL; otherwise pending unchanged and err=1 for one cycle.
- confirm: balance+=pending, pending=0, go to MENU.
- down press: ignored.
REQ-023 WDR:
- down press: pending+=STEP_AMT if pending+STEP_AMT<=balance; otherwise pending unchanged and err=1 for one cycle.
- up press: ignored.
REQ-024 WDR entry check: if balance<STEP_AMT on the down press in MENU, stay in MENU, pending stays 0, err=1 for one cycle.
REQ-025 WDR confirm: on the same edge, balance-=pending and go to DISP.
REQ-026 DISP: dispense=1 for exactly one cycle (decoded from state==DISP); pending held, then pending cleared on the transition to MENU.
REQ-027 Cancel in DEP or WDR: pending=0, go to MENU, balance unchanged.
REQ-028 Confirm and cancel pressed in the same cycle: cancel wins.
REQ-029 Confirm with pending=0 (not reachable by design): go to MENU with no balance change and no dispense.
REQ-030 card_in=0 in any non-IDLE state: go to IDLE and pending=0 on the next edge; balance retained.
REQ-031 Card removal in DISP: the one-cycle dispense pulse completes.
REQ-032 Arithmetic: all arithmetic is 16-bit unsigned; the checks in REQ-022 to REQ-024 are evaluated at 17-bit width so no wrap-around ever occurs.
REQ-033 err is low except for the one-cycle strobes defined here.

Reset
REQ-034 While rst=0: state=IDLE, balance=0, pending=0, dispense=0, err=0, key edge registers=0, timeout counter=0.
REQ-035 Reset applies immediately, independent of clk, including mid-transaction; the staged pending amount is discarded.

Configuration
REQ-036 Macro ATM_TIMEOUT_EN defined: a counter runs in AUTH, MENU, DEP and WDR and clears on any key press or state change.
REQ-037 With ATM_TIMEOUT_EN, when the counter reaches TIMEOUT_CYC: go to IDLE, pending=0, err=1 for one cycle.
REQ-038 Macro ATM_TIMEOUT_EN not defined: no counter is built and the block never times out.

Verification
REQ-039 Reset mid-DEP: with pending=300, assert rst -> state=0, pending=0, balance=0 immediately, with no clk edge required.
REQ-040 Deposit path: card, pin_ok, up x3, confirm -> balance=300, pending=0, state=MENU.
REQ-041 Withdraw path: balance=300, down x2, confirm -> balance=100, dispense high for exactly one cycle, then pending=0.
REQ-042 Withdraw overdraw: balance=100, down x2 -> second press gives err pulse, pending stays 100.
REQ-043 Deposit ceiling: MAX_BAL=200, balance=100, up x2 -> second press gives err pulse, pending stays 100.
REQ-044 Held key and card removal: up_button held 10 cycles -> pending=100; card_in drops in DEP -> IDLE, pending=0, balance unchanged.
REQ-045 Timeout (ATM_TIMEOUT_EN defined, TIMEOUT_CYC=8): idle in MENU for 8 cycles -> IDLE with err pulse.
